// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared state encoding and default widths for the PWM ramp sequencer
package pwm_ctrl_pkg;
  localparam int WORD_LENGTH  = 8;
  localparam int FREQ_LENGTH  = 2;
  localparam int DWELL_LENGTH = 16;
  typedef enum logic [1:0] {IDLE, STEP, DWELL, DONE} state_t;
endpackage

// File: rtl/pwm_ramp_ctrl_dwell_counter.sv
// dwell_counter: loadable down-counter that holds at zero and flags it
module dwell_counter #(
  parameter int W = pwm_ctrl_pkg::DWELL_LENGTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: walks the PWM duty toward a commanded target in bounded steps, one start pulse per step
module pwm_ramp_ctrl #(
  parameter int WORD_LENGTH  = pwm_ctrl_pkg::WORD_LENGTH,
  parameter int FREQ_LENGTH  = pwm_ctrl_pkg::FREQ_LENGTH,
  parameter int DWELL_LENGTH = pwm_ctrl_pkg::DWELL_LENGTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [WORD_LENGTH-1:0]  cmd_duty,
  input  logic [FREQ_LENGTH-1:0]  cmd_freq,
  input  logic [WORD_LENGTH-1:0]  cmd_step,
  input  logic [DWELL_LENGTH-1:0] cmd_dwell,
  input  logic                    abort,
  output logic                    start,
  output logic [WORD_LENGTH-1:0]  dutyCycle,
  output logic [FREQ_LENGTH-1:0]  frequency,
  output logic                    busy,
  output logic                    done
);
  import pwm_ctrl_pkg::*;
  state_t                  state_q, state_d;
  logic [WORD_LENGTH-1:0]  cur_q, cur_d, tgt_q, tgt_d, step_q, step_d, nxt;
  logic [FREQ_LENGTH-1:0]  freq_q, freq_d, lfreq_q, lfreq_d;
  logic [DWELL_LENGTH-1:0] dwell_q, dwell_d;
  logic                    start_q, start_d, done_q, done_d;
  logic                    accept, up, cnt_load, cnt_en, cnt_zero;
  logic [WORD_LENGTH:0]    diff;
  assign cmd_ready = reset && state_q == IDLE && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = state_q != IDLE;
  assign start     = start_q;
  assign done      = done_q;
  assign dutyCycle = cur_q;
  assign frequency = freq_q;
  // distance is taken one bit wider so the final step clamps to target instead of wrapping
  always_comb begin
    up   = tgt_q >= cur_q;
    diff = up ? {1'b0, tgt_q} - {1'b0, cur_q} : {1'b0, cur_q} - {1'b0, tgt_q};
    nxt  = (step_q == '0 || diff <= {1'b0, step_q}) ? tgt_q : up ? cur_q + step_q : cur_q - step_q;
  end
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    freq_d   = freq_q;
    lfreq_d  = lfreq_q;
    dwell_d  = dwell_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        tgt_d   = cmd_duty;
        lfreq_d = cmd_freq;
        step_d  = cmd_step;
        dwell_d = cmd_dwell;
        state_d = STEP;
      end
      STEP: if (abort) state_d = IDLE;
      else begin
        cur_d    = nxt;
        freq_d   = lfreq_q;
        start_d  = 1'b1;
        done_d   = nxt == tgt_q;
        cnt_load = nxt != tgt_q;
        state_d  = nxt == tgt_q ? DONE : DWELL;
      end
      DWELL: begin
        cnt_en  = 1'b1;
        state_d = abort ? IDLE : cnt_zero ? STEP : DWELL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      freq_q  <= '0;
      lfreq_q <= '0;
      dwell_q <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      freq_q  <= freq_d;
      lfreq_q <= lfreq_d;
      dwell_q <= dwell_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end
  dwell_counter #(.W(DWELL_LENGTH)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (dwell_q),
    .zero     (cnt_zero)
  );
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scoreboard bench; expected start pulses are queued at command time and matched as they appear
module tb_pwm_ramp_ctrl;
  logic        clk = 0, reset = 0, cmd_valid = 0, abort = 0;
  logic [7:0]  cmd_duty = 0, cmd_step = 0;
  logic [1:0]  cmd_freq = 0;
  logic [15:0] cmd_dwell = 0;
  logic        cmd_ready, start, busy, done;
  logic [7:0]  dutyCycle;
  logic [1:0]  frequency;
  typedef struct {int cyc; int duty; int freq; bit last;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, fails = 0, model_cur = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pwm_ramp_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_duty(cmd_duty), .cmd_freq(cmd_freq), .cmd_step(cmd_step), .cmd_dwell(cmd_dwell),
    .abort(abort), .start(start), .dutyCycle(dutyCycle), .frequency(frequency),
    .busy(busy), .done(done)
  );
  always @(negedge clk) begin
    if (q.size() > 0 && cyc > q[0].cyc) begin
      checks++; fails++;
      $display("FAIL missing_start: no pulse at cycle %0d, required duty %0d", q[0].cyc, q[0].duty);
      void'(q.pop_front());
    end
    if (start === 1'b1) begin
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        fails++;
        $display("FAIL unexpected_start: cycle %0d duty %0d, required none", cyc, dutyCycle);
      end else begin
        if (dutyCycle !== q[0].duty[7:0] || frequency !== q[0].freq[1:0] || done !== q[0].last) begin
          fails++;
          $display("FAIL pulse_data: cycle %0d got duty=%0d freq=%0d done=%b, required duty=%0d freq=%0d done=%b",
                   cyc, dutyCycle, frequency, done, q[0].duty, q[0].freq, q[0].last);
        end
        void'(q.pop_front());
      end
    end else if (done !== 1'b0) begin
      checks++; fails++;
      $display("FAIL done_alone: cycle %0d done=%b without start, required 0", cyc, done);
    end
  end
  task automatic send_cmd(input int duty, input int freq, input int step, input int dwell, input int limit);
    int acc, c, nxt, diff, k, n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL cmd_ready_wait: got %b, required 1", cmd_ready);
    end
    cmd_valid = 1; cmd_duty = duty[7:0]; cmd_freq = freq[1:0]; cmd_step = step[7:0]; cmd_dwell = dwell[15:0];
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 0;
    c = model_cur; k = 0;
    do begin
      diff = duty > c ? duty - c : c - duty;
      nxt = (step == 0 || diff <= step) ? duty : duty > c ? c + step : c - step;
      if (limit == 0 || k < limit) begin
        q.push_back('{acc + 1 + k * (dwell + 2), nxt, freq, nxt == duty});
        model_cur = nxt;
      end
      c = nxt; k++;
    end while (nxt != duty);
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy !== 1'b0) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout: pending=%0d busy=%b, required 0 and 0", q.size(), busy);
      q.delete();
    end
  endtask
  task automatic test_reset();
    reset = 0; cmd_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({start, done, busy, cmd_ready, dutyCycle, frequency} !== 12'd0) begin
      fails++;
      $display("FAIL reset_outputs: start=%b done=%b busy=%b ready=%b duty=%0d freq=%0d, required all 0",
               start, done, busy, cmd_ready, dutyCycle, frequency);
    end
    cmd_valid = 0; reset = 1;
  endtask
  task automatic test_ramp_up();
    send_cmd(100, 2, 30, 3, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL busy_after_accept: busy=%b ready=%b, required 1 and 0", busy, cmd_ready);
    end
    wait_idle();
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_done: got %b, required 1", cmd_ready);
    end
  endtask
  task automatic test_ramp_down();
    send_cmd(10, 2, 50, 0, 0);
    wait_idle();
    checks++;
    if (dutyCycle !== 8'd10) begin
      fails++;
      $display("FAIL ramp_down_final: got %0d, required 10", dutyCycle);
    end
  endtask
  task automatic test_step_zero();
    send_cmd(200, 3, 0, 5, 0);
    wait_idle();
  endtask
  task automatic test_same_duty();
    send_cmd(200, 1, 20, 2, 0);
    wait_idle();
    checks++;
    if (frequency !== 2'd1 || dutyCycle !== 8'd200) begin
      fails++;
      $display("FAIL same_duty_hold: freq=%0d duty=%0d, required 1 and 200", frequency, dutyCycle);
    end
  endtask
  task automatic test_abort();
    int acc;
    send_cmd(0, 0, 0, 0, 0);
    wait_idle();
    send_cmd(100, 2, 30, 3, 2);
    acc = cyc;
    while (cyc < acc + 7) @(negedge clk);
    abort = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_in_dwell: ready=%b busy=%b, required 0 and 1", cmd_ready, busy);
    end
    @(negedge clk);
    abort = 0;
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_to_idle: busy=%b, required 0", busy);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (dutyCycle !== 8'd60 || q.size() != 0) begin
      fails++;
      $display("FAIL abort_hold: duty=%0d pending=%0d, required 60 and 0", dutyCycle, q.size());
      q.delete();
    end
    send_cmd(0, 0, 60, 2, 0);
    wait_idle();
  endtask
  task automatic test_reset_mid();
    int acc;
    send_cmd(200, 3, 50, 1, 2);
    acc = cyc;
    while (cyc < acc + 5) @(negedge clk);
    reset = 0; cmd_valid = 1; abort = 1;
    @(negedge clk);
    checks++;
    if ({start, done, busy, cmd_ready, dutyCycle, frequency} !== 12'd0) begin
      fails++;
      $display("FAIL reset_mid: start=%b done=%b busy=%b ready=%b duty=%0d freq=%0d, required all 0",
               start, done, busy, cmd_ready, dutyCycle, frequency);
    end
    reset = 1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL abort_blocks_cmd: ready=%b busy=%b, required 0 and 0", cmd_ready, busy);
      end
    end
    abort = 0; cmd_valid = 0;
    model_cur = 0;
    send_cmd(20, 1, 10, 0, 0);
    wait_idle();
  endtask
  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_step_zero();
    test_same_duty();
    test_abort();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
